video_timing_analyzer: RTL

Parametrised video timing analyzer for the HDMI path. It measures line and frame length from the core's `hs`/`vs`/`de` and classifies the standard against two programmable timing sets (PAL, NTSC). Once timing has been stable for a configurable number of frames it asserts `locked`. It then issues a one-cycle `vreset` at a per-mode programmable position, so the HDMI generator can re-align to the core's active video.

---
 rtl/video_timing_analyzer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_analyzer.sv
// ---------------------------------------------------------------------------
// video_timing_analyzer
//
// Measures line and frame length from hs/vs/de and classifies the incoming
// timing as PAL, NTSC or unknown. Once the measured (line, frame) pair has
// repeated for STABLE_FRAMES frames and matches a table entry, it asserts
// locked. It then emits a single-cycle vreset at a mode-specific
// (hcnt, vcnt) position so the HDMI generator can re-align to the core.
//
// Optional feature macro: VIDEO_ANALYZER_ACTIVE_MEAS_EN
//   defined   : h_active / v_active report measured active area
//   undefined : h_active / v_active are tied to 0
//
// Ports
//   clk       in   pixel clock
//   reset_n   in   asynchronous active-low reset
//   hs        in   horizontal sync, falling edge = line start
//   vs        in   vertical sync, sampled at line starts, falling = frame start
//   de        in   data enable
//   mode      out  0 = NTSC, 1 = PAL, 3 = unknown
//   locked    out  timing stable and recognised
//   vreset    out  one-cycle re-alignment pulse
//   h_total   out  last measured line period-1
//   v_total   out  last measured frame period-1 (lines)
//   h_active  out  de-high clocks in last completed line
//   v_active  out  lines with any de in last completed frame
//
// Handshake: there is no valid/ready flow here; every output is a plain
// registered level (vreset is a one-cycle strobe) valid on every clock.
// ---------------------------------------------------------------------------
module video_timing_analyzer #(
    parameter int HW            = 13,
    parameter int VW            = 10,
    parameter int STABLE_FRAMES = 2,
    parameter int PAL_HT        = 863,
    parameter int PAL_VT        = 624,
    parameter int NTSC_HT       = 857,
    parameter int NTSC_VT       = 524,
    parameter int PAL_HOFS      = 68,
    parameter int PAL_VOFS      = 39,
    parameter int NTSC_HOFS     = 60,
    parameter int NTSC_VOFS     = 30
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hs,
    input  logic          vs,
    input  logic          de,
    output logic [1:0]    mode,
    output logic          locked,
    output logic          vreset,
    output logic [HW-1:0] h_total,
    output logic [VW-1:0] v_total,
    output logic [HW-1:0] h_active,
    output logic [VW-1:0] v_active
);

    localparam logic [HW-1:0] H_MAX       = '1;
    localparam logic [VW-1:0] V_MAX       = '1;
    localparam logic [3:0]    SF          = 4'(STABLE_FRAMES);
    localparam logic [HW-1:0] PAL_HT_C    = HW'(PAL_HT);
    localparam logic [VW-1:0] PAL_VT_C    = VW'(PAL_VT);
    localparam logic [HW-1:0] NTSC_HT_C   = HW'(NTSC_HT);
    localparam logic [VW-1:0] NTSC_VT_C   = VW'(NTSC_VT);
    localparam logic [HW-1:0] PAL_HOFS_C  = HW'(PAL_HOFS);
    localparam logic [VW-1:0] PAL_VOFS_C  = VW'(PAL_VOFS);
    localparam logic [HW-1:0] NTSC_HOFS_C = HW'(NTSC_HOFS);
    localparam logic [VW-1:0] NTSC_VOFS_C = VW'(NTSC_VOFS);
    localparam logic [1:0]    MODE_NTSC   = 2'd0;
    localparam logic [1:0]    MODE_PAL    = 2'd1;
    localparam logic [1:0]    MODE_UNK    = 2'd3;

    logic          hs_d;
    logic          vs_d;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [3:0]    stable_cnt;
    logic [HW-1:0] prev_h;
    logic [VW-1:0] prev_v;
    logic          locked_d;
    logic          pending;

    logic          line_edge;
    logic          frame_edge;
    logic [1:0]    cls;
    logic          same_pair;
    logic          at_ofs;
    logic          fire;

    assign line_edge  = !hs && hs_d;
    // vs_d only advances on line edges, so vs is effectively sampled per line.
    assign frame_edge = line_edge && !vs && vs_d;

    // Classification uses h_total before this cycle's update, i.e. the length
    // of the line preceding the one that ends at the frame edge.
    always_comb begin
        cls       = MODE_UNK;
        same_pair = (h_total == prev_h) && (vcnt == prev_v);
        if (h_total == PAL_HT_C && vcnt == PAL_VT_C) begin
            cls = MODE_PAL;
        end else if (h_total == NTSC_HT_C && vcnt == NTSC_VT_C) begin
            cls = MODE_NTSC;
        end
    end

    always_comb begin
        at_ofs = 1'b0;
        case (mode)
            MODE_PAL:  at_ofs = (hcnt == PAL_HOFS_C)  && (vcnt == PAL_VOFS_C);
            MODE_NTSC: at_ofs = (hcnt == NTSC_HOFS_C) && (vcnt == NTSC_VOFS_C);
            default:   at_ofs = 1'b0;
        endcase
        fire = locked && pending && at_ofs;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_d       <= 1'b0;
            vs_d       <= 1'b0;
            hcnt       <= '0;
            vcnt       <= '0;
            h_total    <= '0;
            v_total    <= '0;
            stable_cnt <= '0;
            prev_h     <= '1;
            prev_v     <= '1;
            mode       <= MODE_UNK;
            locked     <= 1'b0;
            locked_d   <= 1'b0;
            pending    <= 1'b0;
            vreset     <= 1'b0;
        end else begin
            hs_d <= hs;

            if (line_edge) begin
                h_total <= hcnt;
                hcnt    <= '0;
                vs_d    <= vs;
                if (frame_edge) begin
                    vcnt <= '0;
                end else if (vcnt != V_MAX) begin
                    vcnt <= vcnt + 1'b1;
                end
            end else if (hcnt != H_MAX) begin
                hcnt <= hcnt + 1'b1;
            end

            if (frame_edge) begin
                if (same_pair) begin
                    stable_cnt <= (stable_cnt == SF) ? SF : stable_cnt + 4'd1;
                end else begin
                    stable_cnt <= '0;
                end
                prev_h  <= h_total;
                prev_v  <= vcnt;
                v_total <= vcnt;
                mode    <= cls;
            end

            locked   <= (stable_cnt == SF) && (mode != MODE_UNK);
            locked_d <= locked;
            vreset   <= fire;

            // Set has priority; with non-zero offsets a set and a fire can
            // never land in the same cycle.
            if ((locked && !locked_d) || (frame_edge && locked && cls != mode)) begin
                pending <= 1'b1;
            end else if (fire) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef VIDEO_ANALYZER_ACTIVE_MEAS_EN
    logic [HW-1:0] de_cnt;
    logic          line_de;
    logic [VW-1:0] vact;
    logic [VW-1:0] vact_next;

    // Line-with-de count including the line that ends this cycle.
    always_comb begin
        vact_next = vact;
        if (line_de && vact != V_MAX) begin
            vact_next = vact + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de_cnt   <= '0;
            line_de  <= 1'b0;
            vact     <= '0;
            h_active <= '0;
            v_active <= '0;
        end else if (line_edge) begin
            h_active <= de_cnt;
            de_cnt   <= {{(HW-1){1'b0}}, de};
            line_de  <= de;
            if (frame_edge) begin
                v_active <= vact_next;
                vact     <= '0;
            end else begin
                vact <= vact_next;
            end
        end else begin
            if (de && de_cnt != H_MAX) begin
                de_cnt <= de_cnt + 1'b1;
            end
            line_de <= line_de | de;
        end
    end
`else
    assign h_active = '0;
    assign v_active = '0;
`endif

endmodule
